// File: rtl/tmds_multi_enc.sv
// tmds_multi_enc: CH-channel TMDS encoder (video/control/guard band) behind a 2-stage ce pipeline.
// Defining TMDS_ENC_TERC4_EN makes mode 10 emit HDMI TERC4 symbols; otherwise mode 10 acts as control.
module tmds_multi_enc #(
  parameter int CH    = 3,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [1:0]       ch_mode,
  input  logic [8*CH-1:0]  ch_data,
  input  logic [2*CH-1:0]  ch_ctl,
  input  logic [4*CH-1:0]  ch_aux,
  output logic [10*CH-1:0] ch_out,
  output logic             ch_out_valid
);
  localparam logic [1:0] M_VID = 2'b01, M_TERC = 2'b10, M_GB = 2'b11;
  function automatic logic [8:0] qm_enc(input logic [7:0] d);
    logic [3:0] n1;
    logic xn;
    logic [8:0] q;
    n1 = 4'($countones(d));
    xn = n1 > 4'd4 || (n1 == 4'd4 && !d[0]);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : q[i-1] ^ d[i];
    q[8] = ~xn;
    return q;
  endfunction
  function automatic logic [9:0] ctl_code(input logic [1:0] c);
    return c == 2'b00 ? 10'b1101010100 : c == 2'b01 ? 10'b0010101011 :
           c == 2'b10 ? 10'b0101010100 : 10'b1010101011;
  endfunction
`ifdef TMDS_ENC_TERC4_EN
  localparam logic [9:0] TERC4 [16] = '{
    10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
    10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
    10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
    10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
`else
  logic unused_aux;
  assign unused_aux = ^ch_aux;
`endif
  logic [1:0] mode_q, v_q;
  logic       st1;
  // stage 1 only advances once stage 0 holds real input, so ch_out stays 0 while filling
  assign st1 = ce & v_q[0];
  assign ch_out_valid = v_q[1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mode_q <= '0;
      v_q    <= '0;
    end else if (ce) begin
      mode_q <= ch_mode;
      v_q    <= {v_q[0], 1'b1};
    end
  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic [8:0] qm_q;
    logic [1:0] ctl_q;
    logic [9:0] out_q, out_d, vid_out, isl_sym;
    logic signed [CNT_W-1:0] cnt_q, cnt_d, vid_cnt, diff;
    logic [3:0] n1;
    logic qm8, cnt_neg, cnt_pos, d_neg, d_pos, bal, inv;
`ifdef TMDS_ENC_TERC4_EN
    logic [3:0] aux_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) aux_q <= '0;
      else if (ce) aux_q <= ch_aux[4*k +: 4];
    assign isl_sym = TERC4[aux_q];
`else
    assign isl_sym = ctl_code(ctl_q);
`endif
    always_comb begin
      qm8     = qm_q[8];
      n1      = 4'($countones(qm_q[7:0]));
      diff    = CNT_W'({n1, 1'b0}) - CNT_W'(8);
      cnt_neg = cnt_q[CNT_W-1];
      cnt_pos = !cnt_neg && cnt_q != '0;
      d_neg   = diff[CNT_W-1];
      d_pos   = !d_neg && diff != '0;
      bal     = cnt_q == '0 || diff == '0;
      inv     = (cnt_pos && d_pos) || (cnt_neg && d_neg);
      vid_out = bal ? {~qm8, qm8, qm8 ? qm_q[7:0] : ~qm_q[7:0]} :
                inv ? {1'b1, qm8, ~qm_q[7:0]} : {1'b0, qm8, qm_q[7:0]};
      vid_cnt = bal ? (qm8 ? cnt_q + diff : cnt_q - diff) :
                inv ? cnt_q + CNT_W'({qm8, 1'b0}) - diff :
                      cnt_q - CNT_W'({~qm8, 1'b0}) + diff;
      out_d   = mode_q == M_VID  ? vid_out :
                mode_q == M_GB   ? (k == 1 ? 10'b0100110011 : 10'b1011001100) :
                mode_q == M_TERC ? isl_sym : ctl_code(ctl_q);
      cnt_d   = mode_q == M_VID ? vid_cnt : '0;
    end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        qm_q  <= '0;
        ctl_q <= '0;
      end else if (ce) begin
        qm_q  <= qm_enc(ch_data[8*k +: 8]);
        ctl_q <= ch_ctl[2*k +: 2];
      end
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        out_q <= '0;
        cnt_q <= '0;
      end else if (st1) begin
        out_q <= out_d;
        cnt_q <= cnt_d;
      end
    assign ch_out[10*k +: 10] = out_q;
  end
endmodule

// File: doc/tmds_multi_enc.md
# tmds_multi_enc

Parametrised multi-channel TMDS encoder, the successor to the single-channel DVI data encoder. It encodes CH channels in parallel behind a shared two-stage pipeline with a clock enable and per-channel running disparity. Beyond DVI control and video periods it also emits guard bands and, optionally, HDMI TERC4 data-island symbols. It sits between the timing/pixel generator and the 10:1 serialisers.

## Interface
- CH, 3: number of TMDS channels, 1..4.
- CNT_W, 5: width of the signed per-channel disparity counter; minimum 5.
- clk  in  1  pixel-rate clock.
- rst_n  in  1  asynchronous active-low reset.
- ce  in  1  pipeline advance enable; all registers hold while low.
- ch_mode  in  2  period type shared by all channels: 00 control, 01 video, 10 TERC4 data island, 11 guard band.
- ch_data  in  8*CH  video byte; channel k at [8k+7:8k].
- ch_ctl  in  2*CH  control pair {c1,c0}; channel k at [2k+1:2k].
- ch_aux  in  4*CH  TERC4 nibble; channel k at [4k+3:4k].
- ch_out  out  10*CH  encoded symbol; channel k at [10k+9:10k]; bit 0 is serialised first.
- ch_out_valid  out  1  high once the pipeline holds real symbols.

## Operation
- **Stage 0, per channel, registered on ce.**
  - N1 is the popcount of ch_data.
  - If N1>4, or N1==4 with d[0]==0: XNOR chain, qm[8]=0.
  - Otherwise: XOR chain, qm[8]=1.
  - qm[0]=d[0]; qm[i]=qm[i-1] op d[i].
  - Mode, ctl, aux and qm[8:0] are registered together.
- **Stage 1, per channel, registered on ce.** Video mode (01), with N1/N0 the ones/zeros count of qm[7:0] and cnt the disparity counter:
  - cnt==0 or N1==N0:
    - out = {~qm8, qm8, qm8 ? qm[7:0] : ~qm[7:0]}.
    - cnt += qm8 ? N1-N0 : N0-N1.
  - (cnt>0 and N1>N0) or (cnt<0 and N0>N1):
    - out = {1, qm8, ~qm[7:0]}.
    - cnt += 2*qm8 + N0-N1.
  - Otherwise:
    - out = {0, qm8, qm[7:0]}.
    - cnt += -2*(~qm8) + N1-N0.
  - Arithmetic is CNT_W-bit two's complement; with CNT_W≥5 the counter never wraps.
- **Control (00).**
  - Codes: 00→1101010100, 01→0010101011, 10→0101010100, 11→1010101011.
  - cnt is cleared to 0.
- **Guard band (11).**
  - Channel 1 emits 0100110011; every other channel emits 1011001100.
  - cnt is cleared to 0.
- **TERC4 (10).** Encodes ch_aux per the Configuration section; cnt is cleared to 0.
- **Mode changes.** Mode may change on any ce cycle. The first video symbol after a non-video period starts from cnt=0. Channels are fully independent apart from the shared mode and ce.

## Timing
- Latency is 2 ce-qualified cycles from input to ch_out. With ce tied high, input at edge n appears after edge n+2.
- While ce is low, ch_out, ch_out_valid and cnt hold their values.
- ch_out_valid goes high on the 2nd ce-qualified edge after reset release and stays high.
- **Reset values:** ch_out=0, ch_out_valid=0, every cnt=0, all stage registers 0. Reset mid-stream clears immediately and asynchronously, and reset takes priority over ce.
- Video output depends only on the channel's own cnt state; there is no cross-channel combinational path.

## Configuration
- **TMDS_ENC_TERC4_EN defined:** mode 10 emits the TERC4 code for ch_aux nibble 0..F:
  - 0–7: 1010011100, 1001100011, 1011100100, 1011100010, 0101110001, 0100011110, 0110001110, 0100111100.
  - 8–F: 1011001100, 0100111001, 0110011100, 1011000110, 1010001110, 1001110001, 0101100011, 1011000011.
- **Not defined:**
  - ch_aux is ignored.
  - Mode 10 behaves exactly as control mode (00), using ch_ctl.

## Test plan
- **Reset:** rst_n low, then released with ce=1 and mode 00, ctl=00 → ch_out=0 and valid=0 until the 2nd edge; then every channel shows 1101010100 and valid=1.
- **Video balance:** mode 01, data 0x00 repeated from cnt=0 → first symbol 0100000000 (qm8=1, out9=0 branch, data bits 0x00 not inverted), cnt=-8. Then a matching golden model of the algorithm over 10k random bytes on each channel, with |cnt|≤10 at all times.
- **ce stall:** video stream with ce toggling 1,0,0,1 → ch_out and cnt frozen for the two low cycles, with total latency of 2 ce cycles.
- **Mode switch:** video sequence leaving cnt≠0, then a guard band, then video 0x00 → channel 1 shows 0100110011 and the others 1011001100; the next video symbol is encoded from cnt=0.
- **TERC4 (macro on):** mode 10, aux=0x5 on all channels → 0100011110 on all channels. With the macro off, mode 10 with ctl=11 → 1010101011.
- **Async reset mid-stream:** rst_n pulsed low between clock edges during video → outputs 0 immediately; after release, the first video symbol starts from cnt=0.
